// File: rtl/data_cache_ctrl_if.sv
// Core request/response and DDR burst signals of the single-line data cache controller.
// master = core/DDR environment, slave = data_cache_ctrl.
interface data_cache_ctrl_if #(
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned ADDR_WIDTH_MEM = 16,
    parameter int unsigned DDR_ADDR_WIDTH = 28
);
    logic                      core_rd_req;
    logic                      core_wr_req;
    logic [ADDR_WIDTH_MEM-1:0] core_addr;
    logic [DATA_WIDTH-1:0]     core_wdata;
    logic [DATA_WIDTH-1:0]     core_rdata;
    logic                      core_ack;

    logic                      DATA_read_req;
    logic                      DATA_store_req;
    logic [DDR_ADDR_WIDTH-1:0] DATA_read_addr;
    logic [DDR_ADDR_WIDTH-1:0] DATA_write_addr;
    logic [DATA_WIDTH-1:0]     DATA_to_ddr;
    logic [DATA_WIDTH-1:0]     DATA_to_cache;

    logic                      ddr_rd_valid;
    logic                      ddr_rd_finish;
    logic                      ddr_wr_data_req;
    logic                      ddr_wr_finish;
    logic [15:0]               hit_cnt;
    logic [15:0]               miss_cnt;

    modport slave (
        input  core_rd_req, core_wr_req, core_addr, core_wdata,
        output core_rdata, core_ack,
        output DATA_read_req, DATA_store_req, DATA_read_addr, DATA_write_addr, DATA_to_ddr,
        input  DATA_to_cache, ddr_rd_valid, ddr_rd_finish, ddr_wr_data_req, ddr_wr_finish,
        output hit_cnt, miss_cnt
    );

    modport master (
        output core_rd_req, core_wr_req, core_addr, core_wdata,
        input  core_rdata, core_ack,
        input  DATA_read_req, DATA_store_req, DATA_read_addr, DATA_write_addr, DATA_to_ddr,
        output DATA_to_cache, ddr_rd_valid, ddr_rd_finish, ddr_wr_data_req, ddr_wr_finish,
        input  hit_cnt, miss_cnt
    );
endinterface

// File: rtl/data_cache_ctrl.sv
// Single-line direct-mapped write-back data cache with DDR burst writeback/fill.
// Optional hit/miss counters are built only when DCACHE_PERF_CNT_EN is defined.
module data_cache_ctrl #(
    parameter int unsigned               DATA_WIDTH       = 16,
    parameter int unsigned               ADDR_WIDTH_MEM   = 16,
    parameter int unsigned               DDR_ADDR_WIDTH   = 28,
    parameter int unsigned               DATA_CACHE_DEPTH = 16,
    parameter logic [DDR_ADDR_WIDTH-1:0] DATA_DDR_BASE    = 28'h0008000
) (
    input logic              mem_clk,
    input logic              rst,
    data_cache_ctrl_if.slave bus
);
    localparam int unsigned      OFF_W     = $clog2(DATA_CACHE_DEPTH);
    localparam int unsigned      CNT_W     = OFF_W + 1;
    localparam int unsigned      TAG_W     = ADDR_WIDTH_MEM - OFF_W;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(DATA_CACHE_DEPTH - 1);
    localparam logic [CNT_W-1:0] BEAT_STOP = CNT_W'(DATA_CACHE_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, RESP, WB, FILL} state_t;

    state_t                    state;
    logic [DATA_WIDTH-1:0]     line [DATA_CACHE_DEPTH];
    logic [TAG_W-1:0]          tag;
    logic [TAG_W-1:0]          miss_tag;
    logic                      valid;
    logic                      dirty;
    logic [CNT_W-1:0]          wb_cnt;
    logic [CNT_W-1:0]          beat_cnt;
    logic                      rd_valid_q;
    logic                      ack;
    logic                      rd_req;
    logic                      st_req;
    logic [DATA_WIDTH-1:0]     rdata;
    logic [DATA_WIDTH-1:0]     to_ddr;
    logic [DDR_ADDR_WIDTH-1:0] rd_addr;
    logic [DDR_ADDR_WIDTH-1:0] wr_addr;

    logic [TAG_W-1:0]          req_tag_c;
    logic [OFF_W-1:0]          req_off_c;
    logic                      lookup_c;
    logic                      hit_c;
    logic [CNT_W-1:0]          wb_cnt_nxt_c;
    logic                      line_we_c;
    logic [OFF_W-1:0]          line_waddr_c;
    logic [DATA_WIDTH-1:0]     line_wdata_c;

    function automatic logic [DDR_ADDR_WIDTH-1:0] line_addr(input logic [TAG_W-1:0] t);
        return DATA_DDR_BASE + DDR_ADDR_WIDTH'({t, {OFF_W{1'b0}}});
    endfunction

    assign req_tag_c = bus.core_addr[ADDR_WIDTH_MEM-1:OFF_W];
    assign req_off_c = bus.core_addr[OFF_W-1:0];
    // A lookup is held off during the ack cycle so the dropping request is not re-served.
    assign lookup_c     = (state == IDLE) && !ack && (bus.core_rd_req || bus.core_wr_req);
    assign hit_c        = lookup_c && valid && (tag == req_tag_c);
    assign wb_cnt_nxt_c = (wb_cnt == LAST_WORD) ? wb_cnt : wb_cnt + CNT_W'(1);

    // Line write port: write hits from the core, fill beats 1..DEPTH from DDR.
    always_comb begin
        line_we_c    = 1'b0;
        line_waddr_c = req_off_c;
        line_wdata_c = bus.core_wdata;
        if (hit_c && bus.core_wr_req && !bus.core_rd_req) begin
            line_we_c = 1'b1;
        end else if (state == FILL && rd_valid_q && beat_cnt != '0 && beat_cnt < BEAT_STOP) begin
            line_we_c    = 1'b1;
            line_waddr_c = OFF_W'(beat_cnt - CNT_W'(1));
            line_wdata_c = bus.DATA_to_cache;
        end
    end

    always_ff @(posedge mem_clk) begin
        if (line_we_c) line[line_waddr_c] <= line_wdata_c;
    end

    always_ff @(posedge mem_clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            tag        <= '0;
            miss_tag   <= '0;
            valid      <= 1'b0;
            dirty      <= 1'b0;
            wb_cnt     <= '0;
            beat_cnt   <= '0;
            rd_valid_q <= 1'b0;
            ack        <= 1'b0;
            rd_req     <= 1'b0;
            st_req     <= 1'b0;
            rdata      <= '0;
            to_ddr     <= '0;
            rd_addr    <= '0;
            wr_addr    <= '0;
        end else begin
            ack        <= 1'b0;
            rd_valid_q <= (state == FILL) && bus.ddr_rd_valid;
            case (state)
                IDLE: begin
                    if (hit_c) begin
                        if (bus.core_rd_req) rdata <= line[req_off_c];
                        else                 dirty <= 1'b1;
                        state <= RESP;
                    end else if (lookup_c) begin
                        miss_tag <= req_tag_c;
                        if (valid && dirty) begin
                            state   <= WB;
                            st_req  <= 1'b1;
                            wr_addr <= line_addr(tag);
                            wb_cnt  <= '0;
                            to_ddr  <= line[{OFF_W{1'b0}}];
                        end else begin
                            state    <= FILL;
                            rd_req   <= 1'b1;
                            rd_addr  <= line_addr(req_tag_c);
                            beat_cnt <= '0;
                        end
                    end
                end
                RESP: begin
                    ack   <= 1'b1;
                    state <= IDLE;
                end
                WB: begin
                    if (bus.ddr_wr_data_req) begin
                        st_req <= 1'b0;
                        wb_cnt <= wb_cnt_nxt_c;
                        to_ddr <= line[wb_cnt_nxt_c[OFF_W-1:0]];
                    end
                    if (bus.ddr_wr_finish) begin
                        dirty    <= 1'b0;
                        st_req   <= 1'b0;
                        state    <= FILL;
                        rd_req   <= 1'b1;
                        rd_addr  <= line_addr(miss_tag);
                        beat_cnt <= '0;
                    end
                end
                FILL: begin
                    if (bus.ddr_rd_valid) rd_req <= 1'b0;
                    if (rd_valid_q && beat_cnt != BEAT_STOP) beat_cnt <= beat_cnt + CNT_W'(1);
                    if (bus.ddr_rd_finish) begin
                        tag    <= miss_tag;
                        valid  <= 1'b1;
                        dirty  <= 1'b0;
                        rd_req <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.core_ack        = ack;
    assign bus.core_rdata      = rdata;
    assign bus.DATA_read_req   = rd_req;
    assign bus.DATA_store_req  = st_req;
    assign bus.DATA_read_addr  = rd_addr;
    assign bus.DATA_write_addr = wr_addr;
    assign bus.DATA_to_ddr     = to_ddr;

`ifdef DCACHE_PERF_CNT_EN
    logic [15:0] hits;
    logic [15:0] misses;

    // Saturating lookup counters; the re-lookup after a fill lands as a hit.
    always_ff @(posedge mem_clk or posedge rst) begin
        if (rst) begin
            hits   <= '0;
            misses <= '0;
        end else begin
            if (hit_c && hits != 16'hFFFF) hits <= hits + 16'd1;
            if (lookup_c && !hit_c && misses != 16'hFFFF) misses <= misses + 16'd1;
        end
    end

    assign bus.hit_cnt  = hits;
    assign bus.miss_cnt = misses;
`else
    assign bus.hit_cnt  = 16'h0000;
    assign bus.miss_cnt = 16'h0000;
`endif
endmodule
